// File: rtl/calc_mp.sv
// rtl/calc_mp.sv - multi-port two-cycle request calculator sharing one pipelined ALU
module calc_mp #(
  parameter int N_PORTS    = 4,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 2,
  parameter int SAT_MODE   = 0
) (
  input  logic                      c_clk,
  input  logic                      reset,
  input  logic [4*N_PORTS-1:0]      req_cmd_in,
  input  logic [DATA_W*N_PORTS-1:0] req_data_in,
  output logic [N_PORTS-1:0]        req_busy,
  output logic [2*N_PORTS-1:0]      out_resp,
  output logic [DATA_W*N_PORTS-1:0] out_data
);
  localparam int PORT_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int SH_W   = $clog2(DATA_W);
  localparam logic [1:0] RESP_OK  = 2'd1;
  localparam logic [1:0] RESP_ERR = 2'd2;

  logic [N_PORTS-1:0]        fifo_empty;
  logic [4*N_PORTS-1:0]      head_cmd;
  logic [DATA_W*N_PORTS-1:0] head_op1;
  logic [DATA_W*N_PORTS-1:0] head_op2;

  logic              gnt_valid;
  logic [PORT_W-1:0] gnt_port;
  logic [PORT_W-1:0] rr_ptr;

  for (genvar p = 0; p < N_PORTS; p++) begin : g_port
    typedef enum logic {CAP_IDLE = 1'b0, CAP_OP2 = 1'b1} cap_state_e;

    cap_state_e        cap_state;
    cap_state_e        cap_next;
    logic [3:0]        cmd;
    logic [DATA_W-1:0] data;
    logic              cap_start;
    logic              push;
    logic              pop;
    logic              full;
    logic [3:0]        cap_cmd;
    logic [DATA_W-1:0] cap_op1;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;
    logic [3:0]        mem_cmd [FIFO_DEPTH];
    logic [DATA_W-1:0] mem_op1 [FIFO_DEPTH];
    logic [DATA_W-1:0] mem_op2 [FIFO_DEPTH];

    assign cmd  = req_cmd_in[4*p +: 4];
    assign data = req_data_in[DATA_W*p +: DATA_W];
    assign full = (count == (PTR_W+1)'(FIFO_DEPTH));
    assign pop  = gnt_valid && (gnt_port == PORT_W'(p));

    always_ff @(posedge c_clk or negedge reset) begin
      if (!reset) cap_state <= CAP_IDLE;
      else        cap_state <= cap_next;
    end

    always_comb begin
      cap_next = cap_state;
      case (cap_state)
        CAP_IDLE: if (cmd != 4'd0 && !full) cap_next = CAP_OP2;
        CAP_OP2:  cap_next = CAP_IDLE;
        default:  cap_next = CAP_IDLE;
      endcase
    end

    // A request seen while busy is dropped whole; the second cycle is never captured.
    always_comb begin
      cap_start = (cap_state == CAP_IDLE) && (cmd != 4'd0) && !full;
      push      = (cap_state == CAP_OP2);
    end

    always_ff @(posedge c_clk or negedge reset) begin
      if (!reset) begin
        cap_cmd <= '0;
        cap_op1 <= '0;
      end else if (cap_start) begin
        cap_cmd <= cmd;
        cap_op1 <= data;
      end
    end

    always_ff @(posedge c_clk or negedge reset) begin
      if (!reset) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        count <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
      end
    end

    always_ff @(posedge c_clk) begin
      if (push) begin
        mem_cmd[wr_ptr] <= cap_cmd;
        mem_op1[wr_ptr] <= cap_op1;
        mem_op2[wr_ptr] <= data;
      end
    end

    assign fifo_empty[p]                  = (count == '0);
    assign req_busy[p]                    = full;
    assign head_cmd[4*p +: 4]             = mem_cmd[rd_ptr];
    assign head_op1[DATA_W*p +: DATA_W]   = mem_op1[rd_ptr];
    assign head_op2[DATA_W*p +: DATA_W]   = mem_op2[rd_ptr];
  end

  // Search starts at rr_ptr and wraps; first non-empty queue wins.
  always_comb begin
    logic [PORT_W:0]   sum;
    logic [PORT_W-1:0] idx;
    gnt_valid = 1'b0;
    gnt_port  = '0;
    sum       = '0;
    idx       = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      sum = {1'b0, rr_ptr} + (PORT_W+1)'(i);
      if (sum >= (PORT_W+1)'(N_PORTS)) sum = sum - (PORT_W+1)'(N_PORTS);
      idx = sum[PORT_W-1:0];
      if (!gnt_valid && !fifo_empty[idx]) begin
        gnt_valid = 1'b1;
        gnt_port  = idx;
      end
    end
  end

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      rr_ptr <= '0;
    end else if (gnt_valid) begin
      rr_ptr <= (gnt_port == PORT_W'(N_PORTS-1)) ? '0 : gnt_port + 1'b1;
    end
  end

  logic              s1_valid;
  logic [PORT_W-1:0] s1_port;
  logic [3:0]        s1_cmd;
  logic [DATA_W-1:0] s1_op1;
  logic [DATA_W-1:0] s1_op2;

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_port  <= '0;
      s1_cmd   <= '0;
      s1_op1   <= '0;
      s1_op2   <= '0;
    end else begin
      s1_valid <= gnt_valid;
      s1_port  <= gnt_port;
      s1_cmd   <= head_cmd[4*gnt_port +: 4];
      s1_op1   <= head_op1[DATA_W*gnt_port +: DATA_W];
      s1_op2   <= head_op2[DATA_W*gnt_port +: DATA_W];
    end
  end

  logic [DATA_W:0]   sum_ext;
  logic [DATA_W:0]   dif_ext;
  logic [SH_W-1:0]   shamt;
  logic [1:0]        alu_resp;
  logic [DATA_W-1:0] alu_data;

  // Bit DATA_W of the widened sum/difference is the carry or borrow.
  always_comb begin
    sum_ext  = {1'b0, s1_op1} + {1'b0, s1_op2};
    dif_ext  = {1'b0, s1_op1} - {1'b0, s1_op2};
    shamt    = s1_op2[SH_W-1:0];
    alu_resp = RESP_OK;
    alu_data = '0;
    case (s1_cmd)
      4'd1: begin
        if (!sum_ext[DATA_W])    alu_data = sum_ext[DATA_W-1:0];
        else if (SAT_MODE != 0)  alu_data = '1;
        else                     alu_resp = RESP_ERR;
      end
      4'd2: begin
        if (!dif_ext[DATA_W])    alu_data = dif_ext[DATA_W-1:0];
        else if (SAT_MODE == 0)  alu_resp = RESP_ERR;
      end
      4'd5:    alu_data = s1_op1 << shamt;
      4'd6:    alu_data = s1_op1 >> shamt;
      default: alu_resp = RESP_ERR;
    endcase
  end

  logic              s2_valid;
  logic [PORT_W-1:0] s2_port;
  logic [1:0]        s2_resp;
  logic [DATA_W-1:0] s2_data;

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      s2_valid <= 1'b0;
      s2_port  <= '0;
      s2_resp  <= '0;
      s2_data  <= '0;
    end else begin
      s2_valid <= s1_valid;
      s2_port  <= s1_port;
      s2_resp  <= alu_resp;
      s2_data  <= alu_data;
    end
  end

  // Responses are single-cycle pulses; every other port reads zero.
  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      out_resp <= '0;
      out_data <= '0;
    end else begin
      out_resp <= '0;
      out_data <= '0;
      if (s2_valid) begin
        out_resp[2*s2_port +: 2]           <= s2_resp;
        out_data[DATA_W*s2_port +: DATA_W] <= s2_data;
      end
    end
  end

endmodule

// File: tb/tb_calc_mp.sv
// tb/tb_calc_mp.sv - self-checking bench for calc_mp with a transaction-level reference model
module tb_calc_mp;
  localparam int N = 4;
  localparam int W = 32;
  localparam int D = 2;

  logic             c_clk = 1'b0;
  logic             reset;
  logic [4*N-1:0]   req_cmd_in;
  logic [W*N-1:0]   req_data_in;
  logic [N-1:0]     busy0, busy1;
  logic [2*N-1:0]   resp0, resp1;
  logic [W*N-1:0]   data0, data1;

  calc_mp #(.N_PORTS(N), .DATA_W(W), .FIFO_DEPTH(D), .SAT_MODE(0)) dut (
    .c_clk(c_clk), .reset(reset), .req_cmd_in(req_cmd_in), .req_data_in(req_data_in),
    .req_busy(busy0), .out_resp(resp0), .out_data(data0));

  calc_mp #(.N_PORTS(N), .DATA_W(W), .FIFO_DEPTH(D), .SAT_MODE(1)) dut_sat (
    .c_clk(c_clk), .reset(reset), .req_cmd_in(req_cmd_in), .req_data_in(req_data_in),
    .req_busy(busy1), .out_resp(resp1), .out_data(data1));

  always #5 c_clk = ~c_clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  typedef struct { logic [3:0] cmd; logic [W-1:0] op1; logic [W-1:0] op2; } txn_t;
  txn_t mq [N][D+1];
  int   mq_cnt [N];
  bit   pend [N];
  txn_t pend_t [N];
  int   rr;
  bit         sch_v  [4];
  int         sch_p  [4];
  logic [1:0] sch_r0 [4];
  logic [1:0] sch_r1 [4];
  logic [W-1:0] sch_d0 [4];
  logic [W-1:0] sch_d1 [4];

  typedef struct {
    int port; logic [3:0] cmd; logic [W-1:0] op1; logic [W-1:0] op2;
    logic [1:0] r0; logic [W-1:0] d0; logic [1:0] r1; logic [W-1:0] d1;
  } vec_t;
  vec_t vt [11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  function automatic void alu_ref(input logic [3:0] cmd, input logic [W-1:0] a, input logic [W-1:0] b,
                                  input bit sat, output logic [1:0] r, output logic [W-1:0] d);
    logic [63:0] sum;
    sum = {32'd0, a} + {32'd0, b};
    r = 2'd1;
    d = '0;
    case (cmd)
      4'd1: if (sum > 64'hFFFF_FFFF) begin r = sat ? 2'd1 : 2'd2; d = sat ? 32'hFFFF_FFFF : 32'd0; end
            else d = sum[W-1:0];
      4'd2: if (a < b) r = sat ? 2'd1 : 2'd2; else d = a - b;
      4'd5: d = a << b[4:0];
      4'd6: d = a >> b[4:0];
      default: r = 2'd2;
    endcase
  endfunction

  task automatic model_reset();
    for (int p = 0; p < N; p++) begin mq_cnt[p] = 0; pend[p] = 1'b0; end
    for (int s = 0; s < 4; s++) sch_v[s] = 1'b0;
    rr = 0;
  endtask

  task automatic model_step();
    bit busy [N];
    bit found;
    int s_now, s_rsp;
    s_now = cyc % 4;
    s_rsp = (cyc + 3) % 4;
    for (int p = 0; p < N; p++) busy[p] = (mq_cnt[p] == D);
    sch_v[s_now] = 1'b0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      int p;
      p = (rr + i) % N;
      if (!found && mq_cnt[p] > 0) begin
        found = 1'b1;
        alu_ref(mq[p][0].cmd, mq[p][0].op1, mq[p][0].op2, 1'b0, sch_r0[s_rsp], sch_d0[s_rsp]);
        alu_ref(mq[p][0].cmd, mq[p][0].op1, mq[p][0].op2, 1'b1, sch_r1[s_rsp], sch_d1[s_rsp]);
        sch_v[s_rsp] = 1'b1;
        sch_p[s_rsp] = p;
        for (int k = 0; k < mq_cnt[p] - 1; k++) mq[p][k] = mq[p][k+1];
        mq_cnt[p]--;
        rr = (p + 1) % N;
      end
    end
    for (int p = 0; p < N; p++) begin
      if (pend[p]) begin
        mq[p][mq_cnt[p]] = '{pend_t[p].cmd, pend_t[p].op1, req_data_in[W*p +: W]};
        mq_cnt[p]++;
        pend[p] = 1'b0;
      end else if (req_cmd_in[4*p +: 4] != 4'd0 && !busy[p]) begin
        pend[p] = 1'b1;
        pend_t[p] = '{req_cmd_in[4*p +: 4], req_data_in[W*p +: W], '0};
      end
    end
    cyc++;
  endtask

  task automatic check_outputs();
    int s;
    logic [N-1:0] eb;
    s = cyc % 4;
    for (int p = 0; p < N; p++) begin
      logic [1:0] er0, er1;
      logic [W-1:0] ed0, ed1;
      er0 = 2'd0; er1 = 2'd0; ed0 = '0; ed1 = '0;
      if (sch_v[s] && sch_p[s] == p) begin
        er0 = sch_r0[s]; er1 = sch_r1[s]; ed0 = sch_d0[s]; ed1 = sch_d1[s];
      end
      eb[p] = (mq_cnt[p] == D);
      check($sformatf("model resp p%0d", p), resp0[2*p +: 2], er0);
      check($sformatf("model sat resp p%0d", p), resp1[2*p +: 2], er1);
      if (er0 != 2'd0 || !reset) check($sformatf("model data p%0d", p), data0[W*p +: W], ed0);
      if (er1 != 2'd0 || !reset) check($sformatf("model sat data p%0d", p), data1[W*p +: W], ed1);
    end
    check("model busy", busy0, eb);
    check("model sat busy", busy1, eb);
  endtask

  task automatic tick();
    @(posedge c_clk);
    if (!reset) model_reset();
    else        model_step();
    @(negedge c_clk);
    check_outputs();
  endtask

  task automatic clear_req();
    req_cmd_in  = '0;
    req_data_in = '0;
  endtask

  task automatic set_req(input int p, input logic [3:0] cmd, input logic [W-1:0] d);
    req_cmd_in[4*p +: 4] = cmd;
    req_data_in[W*p +: W] = d;
  endtask

  task automatic do_reset();
    clear_req();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  function automatic logic [W-1:0] rand_op();
    case ($urandom_range(0, 3))
      0: return W'($urandom);
      1: return '1;
      2: return W'($urandom_range(0, 40));
      default: return 32'h8000_0000;
    endcase
  endfunction

  initial begin
    bit busy2_seen;
    vt[0]  = '{0, 4'd1,  32'h1,         32'h01FF_FFFF, 2'd1, 32'h0200_0000, 2'd1, 32'h0200_0000};
    vt[1]  = '{0, 4'd1,  32'hFFFF_FFFF, 32'h1,         2'd2, 32'h0,         2'd1, 32'hFFFF_FFFF};
    vt[2]  = '{1, 4'd2,  32'h1,         32'hF,         2'd2, 32'h0,         2'd1, 32'h0};
    vt[3]  = '{1, 4'd3,  32'h1234,      32'h5,         2'd2, 32'h0,         2'd2, 32'h0};
    vt[4]  = '{1, 4'd4,  32'hFFFF_FFFF, 32'h0,         2'd2, 32'h0,         2'd2, 32'h0};
    vt[5]  = '{2, 4'd2,  32'h10,        32'h3,         2'd1, 32'hD,         2'd1, 32'hD};
    vt[6]  = '{3, 4'd5,  32'h8000_0001, 32'h21,        2'd1, 32'h2,         2'd1, 32'h2};
    vt[7]  = '{3, 4'd6,  32'h8000_0000, 32'd31,        2'd1, 32'h1,         2'd1, 32'h1};
    vt[8]  = '{0, 4'd15, 32'h7,         32'h7,         2'd2, 32'h0,         2'd2, 32'h0};
    vt[9]  = '{2, 4'd1,  32'h7FFF_FFFF, 32'h8000_0000, 2'd1, 32'hFFFF_FFFF, 2'd1, 32'hFFFF_FFFF};
    vt[10] = '{0, 4'd2,  32'h5,         32'h5,         2'd1, 32'h0,         2'd1, 32'h0};

    clear_req();
    reset = 1'b0;
    @(negedge c_clk);
    check("reset resp", resp0, '0);
    check("reset busy", busy0, '0);
    check("reset data", data0, '0);
    do_reset();

    // Isolated requests: response exactly at k+5, gone at k+6.
    for (int v = 0; v < 11; v++) begin
      clear_req(); set_req(vt[v].port, vt[v].cmd, vt[v].op1); tick();
      clear_req(); set_req(vt[v].port, 4'h9, vt[v].op2); tick();
      clear_req(); tick(); tick(); tick();
      check($sformatf("vec%0d resp", v), resp0[2*vt[v].port +: 2], vt[v].r0);
      check($sformatf("vec%0d data", v), data0[W*vt[v].port +: W], vt[v].d0);
      check($sformatf("vec%0d sat resp", v), resp1[2*vt[v].port +: 2], vt[v].r1);
      check($sformatf("vec%0d sat data", v), data1[W*vt[v].port +: W], vt[v].d1);
      tick();
      check($sformatf("vec%0d resp cleared", v), resp0[2*vt[v].port +: 2], 2'd0);
    end

    // All four ports request together right after reset: grants 0,1,2,3.
    do_reset();
    for (int p = 0; p < N; p++) set_req(p, 4'd5, 32'h1);
    tick();
    for (int p = 0; p < N; p++) set_req(p, 4'd0, W'(p + 1));
    tick();
    clear_req(); tick(); tick(); tick();
    for (int j = 0; j < N; j++) begin
      for (int p = 0; p < N; p++)
        check($sformatf("rr order cycle%0d p%0d", j, p), resp0[2*p +: 2], (p == j) ? 2'd1 : 2'd0);
      check($sformatf("rr data p%0d", j), data0[W*j +: W], W'(2) << j);
      tick();
    end

    // Port 2 back-to-back while others flood; the model tracks drops and order.
    do_reset();
    busy2_seen = 1'b0;
    for (int c = 0; c < 24; c++) begin
      for (int p = 0; p < N; p++) set_req(p, 4'd1, W'($urandom_range(0, 255)));
      set_req(2, 4'd1, W'(100 + c));
      tick();
      if (busy0[2]) busy2_seen = 1'b1;
    end
    check("busy2 rises under flood", busy2_seen, 1'b1);
    clear_req();
    for (int c = 0; c < 40; c++) tick();

    // Reset one cycle after the grant discards the in-flight request.
    do_reset();
    set_req(0, 4'd1, 32'h5); tick();
    set_req(0, 4'd0, 32'h6); tick();
    clear_req(); tick(); tick();
    reset = 1'b0;
    tick();
    check("reset mid-flight resp", resp0, '0);
    check("reset mid-flight data", data0, '0);
    tick();
    reset = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      check($sformatf("no late resp %0d", c), resp0[1:0], 2'd0);
    end

    // Randomized traffic with occasional reset pulses.
    for (int c = 0; c < 3000; c++) begin
      for (int p = 0; p < N; p++) begin
        logic [3:0] cmd;
        case ($urandom_range(0, 9))
          0, 1, 2, 3: cmd = 4'd0;
          4, 9:       cmd = 4'd1;
          5:          cmd = 4'd2;
          6:          cmd = 4'd5;
          7:          cmd = 4'd6;
          default:    cmd = 4'($urandom_range(0, 15));
        endcase
        set_req(p, cmd, rand_op());
      end
      reset = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
      tick();
    end
    reset = 1'b1;
    clear_req();
    for (int c = 0; c < 30; c++) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
